// File: rtl/idct8_row_sequencer.sv
// rtl/idct8_row_sequencer.sv - row scheduler for a chain of 8 systolic IDCT-8 MAC modules
module idct8_row_sequencer #(
    parameter int DW     = 25,
    parameter int SW     = 4,
    parameter int ROWS   = 8,
    parameter int SHIFT1 = 7,
    parameter int ADD1   = 64,
    parameter int SHIFT2 = 12,
    parameter int ADD2   = 2048
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*DW-1:0] in_data,
    output logic [8*DW-1:0] dp_d_in,
    output logic [8*SW-1:0] dp_shift,
    output logic [8*DW-1:0] dp_add,
    input  logic [8*DW-1:0] dp_d_out,
    output logic            out_valid,
    output logic [8*DW-1:0] out_data,
    output logic            out_pass,
    output logic            busy,
    output logic            block_done
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [SW-1:0] SH1 = SW'(SHIFT1);
    localparam logic [SW-1:0] SH2 = SW'(SHIFT2);
    localparam logic [DW-1:0] AD1 = DW'(ADD1);
    localparam logic [DW-1:0] AD2 = DW'(ADD2);

    typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_cnt;
    logic            accept;
    logic            last_row;
    logic [16:0]     tag_v;
    logic [16:0]     tag_p;
    logic [16:0]     tag_l;
    logic [8*DW-1:0] aligned;

    assign in_ready = (state_q == S_P1) || (state_q == S_P2);
    assign accept   = in_valid & in_ready;
    assign last_row = (row_cnt == CW'(ROWS - 1));
    assign busy     = (state_q != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: a pass ends on its ROWS-th accepted row, the block ends with block_done
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)               state_d = S_P1;
            S_P1:    if (accept && last_row)  state_d = S_P2;
            S_P2:    if (accept && last_row)  state_d = S_DRAIN;
            S_DRAIN: if (block_done)          state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Row counter: advances only on accepted rows, wraps to 0 at each pass change
    always_ff @(posedge clk) begin
        if (reset)       row_cnt <= '0;
        else if (accept) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
    end

    // Tag line: bit j describes the row accepted j+1 edges ago (valid, pass-2, last of block)
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            tag_p <= '0;
            tag_l <= '0;
        end else begin
            tag_v <= {tag_v[15:0], accept};
            tag_p <= {tag_p[15:0], accept && (state_q == S_P2)};
            tag_l <= {tag_l[15:0], accept && (state_q == S_P2) && last_row};
        end
    end

    for (genvar k = 1; k <= 8; k++) begin : g_skew
        logic [DW-1:0] pipe [0:k];

        // Sample k is delayed k cycles past the accept edge; idle slots carry zero
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j <= k; j++) pipe[j] <= '0;
            end else begin
                pipe[0] <= accept ? in_data[k*DW-1 -: DW] : '0;
                for (int j = 1; j <= k; j++) pipe[j] <= pipe[j-1];
            end
        end

        assign dp_d_in[k*DW-1 -: DW] = pipe[k];
    end

    for (genvar m = 1; m <= 8; m++) begin : g_mod
        // Module m finishes its row at tag position 7+m, so its config follows that tag
        assign dp_shift[m*SW-1 -: SW] = (tag_v[7+m] && tag_p[7+m]) ? SH2 : SH1;
        assign dp_add[m*DW-1 -: DW]   = (tag_v[7+m] && tag_p[7+m]) ? AD2 : AD1;

        if (m < 8) begin : g_dly
            logic [DW-1:0] pipe [0:7-m];

            // Earlier modules finish earlier; hold their result until module 8 catches up
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j <= 7 - m; j++) pipe[j] <= '0;
                end else begin
                    pipe[0] <= dp_d_out[m*DW-1 -: DW];
                    for (int j = 1; j <= 7 - m; j++) pipe[j] <= pipe[j-1];
                end
            end

            assign aligned[m*DW-1 -: DW] = pipe[7-m];
        end else begin : g_last
            assign aligned[m*DW-1 -: DW] = dp_d_out[m*DW-1 -: DW];
        end
    end

    // Output register: present the aligned vector once per row, hold it otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pass   <= 1'b0;
            block_done <= 1'b0;
        end else begin
            out_valid  <= tag_v[16];
            block_done <= tag_l[16];
            if (tag_v[16]) begin
                out_data <= aligned;
                out_pass <= tag_p[16];
            end
        end
    end

endmodule

// File: tb/tb_idct8_row_sequencer.sv
// tb/tb_idct8_row_sequencer.sv - self-checking bench for idct8_row_sequencer
module tb_idct8_row_sequencer;

    localparam int DW = 25;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8*DW-1:0] in_data = '0;
    logic [8*DW-1:0] dp_d_in;
    logic [8*SW-1:0] dp_shift;
    logic [8*DW-1:0] dp_add;
    logic [8*DW-1:0] dp_d_out = '0;
    logic            out_valid;
    logic [8*DW-1:0] out_data;
    logic            out_pass;
    logic            busy;
    logic            block_done;

    idct8_row_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_d_in(dp_d_in), .dp_shift(dp_shift), .dp_add(dp_add), .dp_d_out(dp_d_out),
        .out_valid(out_valid), .out_data(out_data), .out_pass(out_pass),
        .busy(busy), .block_done(block_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int coef [0:7][0:7] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [8*DW-1:0] idct(input logic [8*DW-1:0] d, input bit p);
        logic [8*DW-1:0] r;
        longint acc;
        for (int m = 0; m < 8; m++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) acc += coef[k][m] * sx(d[k*DW +: DW]);
            acc = (acc + (p ? 2048 : 64)) >>> (p ? 12 : 7);
            r[m*DW +: DW] = acc[DW-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural chain of 8 MAC modules: module m sees sample k at cycle t+k+m-1,
    // applies its shift/add at t+7+m and presents d_out from t+8+m
    logic [8*DW-1:0] hist [0:13];
    initial for (int j = 0; j < 14; j++) hist[j] = '0;

    always @(posedge clk) begin : chain_model
        longint          acc;
        int              dl;
        logic [8*DW-1:0] v;
        for (int m = 0; m < 8; m++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                dl = m + 7 - k;
                v  = (dl == 0) ? dp_d_in : hist[dl-1];
                acc += coef[k][m] * sx(v[k*DW +: DW]);
            end
            acc = (acc + sx(dp_add[m*DW +: DW])) >>> dp_shift[m*SW +: SW];
            dp_d_out[m*DW +: DW] <= acc[DW-1:0];
        end
        hist[0] <= dp_d_in;
        for (int j = 1; j < 14; j++) hist[j] <= hist[j-1];
    end

    typedef struct {
        logic [8*DW-1:0] exp;
        bit              pass;
        bit              last;
        int              acc;
    } sb_t;
    sb_t sbq[$];

    int n_out = 0;
    int n_bd  = 0;
    bit prev_bd = 1'b0;

    // Output monitor: pop the scoreboard on each out_valid, check data, pass, latency, done
    always @(negedge clk) begin : monitor
        sb_t e;
        if (!reset) begin
            if (prev_bd) chk("busy_after_done", busy, 0);
            if (out_valid) begin
                n_out++;
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chkv("out_data", out_data, e.exp);
                    chk("out_pass", out_pass, e.pass);
                    chk("latency", cyc - e.acc, 17);
                    chk("block_done", block_done, e.last);
                    if (e.last) chk("busy_at_done", busy, 1);
                end
            end else if (block_done) begin
                chk("block_done_without_valid", 1, 0);
            end
            if (block_done) n_bd++;
        end
        prev_bd = block_done;
    end

    typedef struct {
        logic [8*DW-1:0] x;
        bit              pass;
        logic [8*DW-1:0] exp;
    } vec_t;
    vec_t tbl [16];

    logic [8*DW-1:0] r64;
    logic [8*DW-1:0] rneg64;

    function automatic logic [8*DW-1:0] rand_row();
        logic [8*DW-1:0] d;
        int v;
        for (int k = 0; k < 8; k++) begin
            v = int'($urandom_range(0, 512)) - 256;
            d[k*DW +: DW] = DW'(v);
        end
        return d;
    endfunction

    task automatic send_row(input logic [8*DW-1:0] d, input logic [8*DW-1:0] exp,
                            input bit p, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        sbq.push_back('{exp, p, last, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || sbq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 300, 1);
        @(negedge clk);
    endtask

    task automatic run_block(input logic [8*DW-1:0] rows [16], input bit bubble, input bit start_mid);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (bubble && i > 0) @(negedge clk);
            if (start_mid && i == 10) pulse_start();
            send_row(rows[i], idct(rows[i], i >= 8), i >= 8, i == 15);
        end
        chk("in_ready_in_drain", in_ready, 0);
        wait_done();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [8*DW-1:0] rows [16];
        int              n_before;

        r64    = '0;
        r64[DW-1:0] = DW'(64);
        rneg64 = '0;
        rneg64[DW-1:0] = DW'(-64);

        for (int i = 0; i < 16; i++) begin
            tbl[i].x    = rand_row();
            tbl[i].pass = (i >= 8);
            tbl[i].exp  = idct(tbl[i].x, tbl[i].pass);
        end
        tbl[0] = '{r64,    1'b0, {8{DW'(32)}}};
        tbl[1] = '{rneg64, 1'b0, {8{DW'(-32)}}};
        tbl[8] = '{r64,    1'b1, {8{DW'(1)}}};
        tbl[9] = '{rneg64, 1'b1, {8{DW'(-1)}}};

        // Reset held 3 cycles with in_valid toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
        end
        chk("reset_in_ready_iv1", in_ready, 0);
        in_valid = 1'b0;
        #1;
        chk("reset_in_ready_iv0", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chkv("reset_out_data", out_data, '0);
        chk("reset_out_pass", out_pass, 0);
        chk("reset_busy", busy, 0);
        chk("reset_block_done", block_done, 0);
        chkv("reset_dp_d_in", dp_d_in, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Single pass-1 row, observed alone, then the rest of the block
        pulse_start();
        chk("busy_after_start", busy, 1);
        send_row(r64, {8{DW'(32)}}, 1'b0, 1'b0);
        n_before = n_out;
        for (int n = 0; n < 40 && sbq.size() != 0; n++) @(negedge clk);
        chk("single_row_outputs", n_out - n_before, 1);
        for (int i = 1; i < 16; i++)
            send_row(r64, i >= 8 ? {8{DW'(1)}} : {8{DW'(32)}}, i >= 8, i == 15);
        wait_done();

        // Full back-to-back block of {64,0,...}
        for (int i = 0; i < 16; i++) rows[i] = r64;
        run_block(rows, 1'b0, 1'b0);

        // Table-driven block, back-to-back
        pulse_start();
        for (int i = 0; i < 16; i++) send_row(tbl[i].x, tbl[i].exp, tbl[i].pass, i == 15);
        chk("tbl_in_ready_in_drain", in_ready, 0);
        wait_done();

        // Bubbles every other cycle
        for (int i = 0; i < 16; i++) rows[i] = rand_row();
        run_block(rows, 1'b1, 1'b0);

        // Start pulsed during pass 2 is ignored
        n_before = n_bd;
        for (int i = 0; i < 16; i++) rows[i] = rand_row();
        run_block(rows, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("start_mid_busy", busy, 0);
        chk("start_mid_done_count", n_bd - n_before, 1);

        // Reset after 5 pass-1 rows drops everything in flight
        pulse_start();
        for (int i = 0; i < 5; i++) send_row(r64, {8{DW'(32)}}, 1'b0, 1'b0);
        reset = 1'b1;
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        for (int i = 0; i < 16; i++) rows[i] = rand_row();
        run_block(rows, 1'b0, 1'b0);

        chk("total_out_count", n_out, 96);
        chk("total_block_done", n_bd, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
